// File: rtl/ysyx_210184_mem_stage_pkg.sv
// Shared definitions for the memory-access stage: funct3 load/store codes,
// FSM state encoding and small alignment helpers.
package ysyx_210184_mem_stage_pkg;

    localparam int REG_BUS = 64;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_D  = 3'b011;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;
    localparam logic [2:0] LS_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] store_mask(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 8'h01 << off;
            2'b01:   return 8'h03 << off;
            2'b10:   return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_210184_mem_stage_if.sv
// Data-memory request/grant plus response-valid bus between the MEM stage
// (master) and the data memory (slave).
interface ysyx_210184_mem_stage_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wmask;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ysyx_210184_mem_stage_ff.sv
// Plain D flip-flop with synchronous active-low reset to a parameterised value.
module ysyx_210184_ff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/ysyx_210184_mem_stage_load_align.sv
// Load data formatting: pick the addressed lane out of the returned
// doubleword and sign- or zero-extend it according to funct3.
module ysyx_210184_load_align
    import ysyx_210184_mem_stage_pkg::*;
(
    input  logic [REG_BUS-1:0] rdata,
    input  logic [2:0]         off,
    input  logic [2:0]         funct3,
    output logic [REG_BUS-1:0] data
);
    logic [REG_BUS-1:0] lane;

    assign lane = rdata >> {off, 3'b000};

    always_comb begin
        data = lane;
        case (funct3)
            LS_B:    data = {{56{lane[7]}},  lane[7:0]};
            LS_H:    data = {{48{lane[15]}}, lane[15:0]};
            LS_W:    data = {{32{lane[31]}}, lane[31:0]};
            LS_D:    data = lane;
            LS_BU:   data = {56'd0, lane[7:0]};
            LS_HU:   data = {48'd0, lane[15:0]};
            LS_WU:   data = {32'd0, lane[31:0]};
            default: data = lane;
        endcase
    end
endmodule

// File: rtl/ysyx_210184_mem_stage.sv
// Memory-access stage: issues loads/stores over the req/gnt/rvalid bus,
// stalls upstream while an access is outstanding and drives the MEM/WB register.
module ysyx_210184_mem_stage
    import ysyx_210184_mem_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_ena_i,
    input  logic              store_ena_i,
    input  logic [2:0]        ls_bytes_i,
    input  logic [4:0]        rd_i,
    input  logic              w_rd_ena_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic              inst_valid_i,
    ysyx_210184_mem_stage_if.master mem,
    output logic              stall_o,
    output logic              misalign_o,
    output logic [4:0]        rd_o,
    output logic              w_rd_ena_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              inst_valid_o
);
    mem_state_e state_reg, state_next;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [7:0]        wmask_reg;
    logic [2:0]        funct3_reg;
    logic [2:0]        off_reg;
    logic [4:0]        rd_reg;
    logic              w_rd_ena_reg;
    logic [DATA_W-1:0] alu_reg;

    logic              mem_op;
    logic              misaligned;
    logic              start_op;
    logic [2:0]        off;
    logic              stall_raw;
    logic [DATA_W-1:0] load_data;

    logic [4:0]        rd_next;
    logic              w_rd_ena_next;
    logic [DATA_W-1:0] wb_data_next;
    logic              inst_valid_next;
    logic              misalign_next;

    assign off        = alu_result_i[2:0];
    assign mem_op     = inst_valid_i & (load_ena_i | store_ena_i);
    assign misaligned = mem_op & is_misaligned(ls_bytes_i, off);
    assign start_op   = mem_op & ~misaligned;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
            funct3_reg   <= '0;
            off_reg      <= '0;
            rd_reg       <= '0;
            w_rd_ena_reg <= 1'b0;
            alu_reg      <= '0;
        end else begin
            state_reg <= state_next;
            // Bus fields are captured once and held until the response returns.
            if (state_reg == ST_IDLE && start_op) begin
                we_reg       <= store_ena_i;
                addr_reg     <= {alu_result_i[ADDR_W-1:3], 3'b000};
                wdata_reg    <= store_ena_i ? (rs2_data_i << {off, 3'b000}) : '0;
                wmask_reg    <= store_ena_i ? store_mask(ls_bytes_i[1:0], off) : 8'h00;
                funct3_reg   <= ls_bytes_i;
                off_reg      <= off;
                rd_reg       <= rd_i;
                w_rd_ena_reg <= w_rd_ena_i & ~store_ena_i;
                alu_reg      <= alu_result_i;
            end
        end
    end

    ysyx_210184_load_align u_load_align (
        .rdata  (mem.rdata),
        .off    (off_reg),
        .funct3 (funct3_reg),
        .data   (load_data)
    );

    always_comb begin
        state_next      = state_reg;
        stall_raw       = 1'b0;
        rd_next         = '0;
        w_rd_ena_next   = 1'b0;
        wb_data_next    = '0;
        inst_valid_next = 1'b0;
        misalign_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                misalign_next = misaligned;
                if (start_op) begin
                    state_next = ST_REQ;
                    stall_raw  = 1'b1;
                end else if (!mem_op) begin
                    rd_next         = rd_i;
                    w_rd_ena_next   = w_rd_ena_i & inst_valid_i;
                    wb_data_next    = alu_result_i;
                    inst_valid_next = inst_valid_i;
                end
            end
            ST_REQ: begin
                stall_raw = 1'b1;
                if (mem.gnt) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem.rvalid) begin
                    state_next      = ST_IDLE;
                    rd_next         = rd_reg;
                    w_rd_ena_next   = w_rd_ena_reg;
                    wb_data_next    = we_reg ? alu_reg : load_data;
                    inst_valid_next = 1'b1;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Gating with rst keeps every output low while reset is asserted.
    assign stall_o   = rst & stall_raw;
    assign mem.req   = rst & (state_reg == ST_REQ);
    assign mem.we    = we_reg;
    assign mem.addr  = addr_reg;
    assign mem.wdata = wdata_reg;
    assign mem.wmask = wmask_reg;

    ysyx_210184_ff #(.W(5)) u_rd_ff (
        .clk(clk), .rst(rst), .d(rd_next), .q(rd_o)
    );
    ysyx_210184_ff #(.W(1)) u_wen_ff (
        .clk(clk), .rst(rst), .d(w_rd_ena_next), .q(w_rd_ena_o)
    );
    ysyx_210184_ff #(.W(DATA_W)) u_wb_data_ff (
        .clk(clk), .rst(rst), .d(wb_data_next), .q(wb_data_o)
    );
    ysyx_210184_ff #(.W(1)) u_valid_ff (
        .clk(clk), .rst(rst), .d(inst_valid_next), .q(inst_valid_o)
    );
    ysyx_210184_ff #(.W(1)) u_misalign_ff (
        .clk(clk), .rst(rst), .d(misalign_next), .q(misalign_o)
    );
endmodule

// File: tb/tb_ysyx_210184_mem_stage.sv
// Directed testbench for ysyx_210184_mem_stage; the data memory is modelled
// cycle by cycle inside each scenario task.
module tb_ysyx_210184_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_ena, store_ena, w_rd_ena, inst_valid;
    logic [2:0]  ls_bytes;
    logic [4:0]  rd;
    logic [63:0] alu_result, rs2_data;
    logic        stall, misalign, w_rd_ena_q, inst_valid_q;
    logic [4:0]  rd_q;
    logic [63:0] wb_data;

    int tests_run    = 0;
    int tests_failed = 0;

    ysyx_210184_mem_stage_if #(.ADDR_W(64), .DATA_W(64)) mem_bus ();

    ysyx_210184_mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .load_ena_i(load_ena), .store_ena_i(store_ena), .ls_bytes_i(ls_bytes),
        .rd_i(rd), .w_rd_ena_i(w_rd_ena), .alu_result_i(alu_result),
        .rs2_data_i(rs2_data), .inst_valid_i(inst_valid),
        .mem(mem_bus),
        .stall_o(stall), .misalign_o(misalign), .rd_o(rd_q),
        .w_rd_ena_o(w_rd_ena_q), .wb_data_o(wb_data), .inst_valid_o(inst_valid_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] r,
                          input logic wen, input logic [63:0] alu, input logic [63:0] rs2, input logic v);
        load_ena = ld; store_ena = st; ls_bytes = f3; rd = r;
        w_rd_ena = wen; alu_result = alu; rs2_data = rs2; inst_valid = v;
    endtask

    task automatic clear_ex();
        set_ex(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 64'd0, 64'd0, 1'b0);
    endtask

    // Minimum-latency access: op at T, gnt at T+1, rvalid at T+2, WB sampled at T+3.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rs2, input logic [63:0] rdata, input logic [4:0] r,
                          output logic stall_t, output logic stall_t1, output logic req_t1,
                          output logic we_t1, output logic [63:0] addr_t1, output logic [63:0] wdata_t1,
                          output logic [7:0] wmask_t1, output logic stall_t2, output logic [63:0] wb_d,
                          output logic wb_v, output logic wb_wen, output logic [4:0] wb_rd);
        tick();
        set_ex(ld, st, f3, r, 1'b1, addr, rs2, 1'b1);
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
        @(negedge clk);
        stall_t = stall;
        tick();
        mem_bus.gnt = 1'b1;
        @(negedge clk);
        stall_t1 = stall; req_t1 = mem_bus.req; we_t1 = mem_bus.we;
        addr_t1 = mem_bus.addr; wdata_t1 = mem_bus.wdata; wmask_t1 = mem_bus.wmask;
        tick();
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = rdata;
        @(negedge clk);
        stall_t2 = stall;
        tick();
        mem_bus.rvalid = 1'b0;
        clear_ex();
        @(negedge clk);
        wb_d = wb_data; wb_v = inst_valid_q; wb_wen = w_rd_ena_q; wb_rd = rd_q;
        $display("[TB] %s f3=%0d addr=%h wmask=%h -> wb_data=%h valid=%b wen=%b",
                 st ? "store" : "load", f3, addr, wmask_t1, wb_d, wb_v, wb_wen);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_ex();
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = 64'd0;
        repeat (3) tick();
        @(negedge clk);
        $display("[TB] reset held");
        tests_run++; if (mem_bus.req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", mem_bus.req); end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests_run++; if (inst_valid_q !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", inst_valid_q); end
        tests_run++; if (w_rd_ena_q !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b want 0", w_rd_ena_q); end
        tests_run++; if (wb_data !== 64'd0) begin tests_failed++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        tests_run++; if (rd_q !== 5'd0) begin tests_failed++; $display("FAIL reset_rd: got %0d want 0", rd_q); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_load_d();
        logic s0, s1, s2, rq, we, v, wen;
        logic [63:0] a, wd, d;
        logic [7:0] wm;
        logic [4:0] r;
        run_op(1'b1, 1'b0, 3'b011, 64'h1000, 64'd0, 64'h8877665544332211, 5'd5,
               s0, s1, rq, we, a, wd, wm, s2, d, v, wen, r);
        tests_run++; if (s0 !== 1'b1) begin tests_failed++; $display("FAIL ld_stall_T: got %b want 1", s0); end
        tests_run++; if (s1 !== 1'b1) begin tests_failed++; $display("FAIL ld_stall_T1: got %b want 1", s1); end
        tests_run++; if (rq !== 1'b1) begin tests_failed++; $display("FAIL ld_req: got %b want 1", rq); end
        tests_run++; if (we !== 1'b0) begin tests_failed++; $display("FAIL ld_we: got %b want 0", we); end
        tests_run++; if (a !== 64'h1000) begin tests_failed++; $display("FAIL ld_addr: got %h want 1000", a); end
        tests_run++; if (s2 !== 1'b0) begin tests_failed++; $display("FAIL ld_stall_T2: got %b want 0", s2); end
        tests_run++; if (d !== 64'h8877665544332211) begin tests_failed++; $display("FAIL ld_wb_data: got %h want 8877665544332211", d); end
        tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL ld_valid: got %b want 1", v); end
        tests_run++; if (wen !== 1'b1) begin tests_failed++; $display("FAIL ld_wen: got %b want 1", wen); end
        tests_run++; if (r !== 5'd5) begin tests_failed++; $display("FAIL ld_rd: got %0d want 5", r); end
        @(negedge clk);
        tests_run++; if (inst_valid_q !== 1'b0) begin tests_failed++; $display("FAIL ld_bubble_after: got %b want 0", inst_valid_q); end
    endtask

    task automatic test_load_extend();
        logic s0, s1, s2, rq, we, v, wen;
        logic [63:0] a, wd, d;
        logic [7:0] wm;
        logic [4:0] r;
        logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110};
        logic [63:0] adr_tab [5] = '{64'h1003, 64'h1003, 64'h1006, 64'h1004, 64'h1004};
        logic [63:0] rd_tab  [5] = '{64'h1122334480AABBCC, 64'h1122334480AABBCC,
                                    64'h8877665544332211, 64'h8877665544332211, 64'h8877665544332211};
        logic [63:0] exp_tab [5] = '{64'hFFFFFFFFFFFFFF80, 64'h0000000000000080,
                                    64'hFFFFFFFFFFFF8877, 64'hFFFFFFFF88776655, 64'h0000000088776655};
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, 1'b0, f3_tab[i], adr_tab[i], 64'd0, rd_tab[i], 5'd9,
                   s0, s1, rq, we, a, wd, wm, s2, d, v, wen, r);
            tests_run++; if (d !== exp_tab[i]) begin tests_failed++; $display("FAIL load_ext[%0d]: got %h want %h", i, d, exp_tab[i]); end
            tests_run++; if (a !== {adr_tab[i][63:3], 3'b000}) begin tests_failed++; $display("FAIL load_ext_addr[%0d]: got %h want %h", i, a, {adr_tab[i][63:3], 3'b000}); end
        end
    endtask

    task automatic test_store();
        logic s0, s1, s2, rq, we, v, wen;
        logic [63:0] a, wd, d;
        logic [7:0] wm;
        logic [4:0] r;
        logic [2:0]  f3_tab  [3] = '{3'b001, 3'b000, 3'b011};
        logic [63:0] adr_tab [3] = '{64'h2002, 64'h2005, 64'h3000};
        logic [63:0] rs2_tab [3] = '{64'hBEEF, 64'hAB, 64'h0123456789ABCDEF};
        logic [7:0]  msk_tab [3] = '{8'h0C, 8'h20, 8'hFF};
        logic [63:0] wd_tab  [3] = '{64'h00000000BEEF0000, 64'h0000AB0000000000, 64'h0123456789ABCDEF};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, 1'b1, f3_tab[i], adr_tab[i], rs2_tab[i], 64'd0, 5'd12,
                   s0, s1, rq, we, a, wd, wm, s2, d, v, wen, r);
            tests_run++; if (wm !== msk_tab[i]) begin tests_failed++; $display("FAIL st_wmask[%0d]: got %h want %h", i, wm, msk_tab[i]); end
            tests_run++; if (wd !== wd_tab[i]) begin tests_failed++; $display("FAIL st_wdata[%0d]: got %h want %h", i, wd, wd_tab[i]); end
            tests_run++; if (we !== 1'b1) begin tests_failed++; $display("FAIL st_we[%0d]: got %b want 1", i, we); end
            tests_run++; if (a !== {adr_tab[i][63:3], 3'b000}) begin tests_failed++; $display("FAIL st_addr[%0d]: got %h want %h", i, a, {adr_tab[i][63:3], 3'b000}); end
            tests_run++; if (wen !== 1'b0) begin tests_failed++; $display("FAIL st_wen[%0d]: got %b want 0", i, wen); end
            tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL st_valid[%0d]: got %b want 1", i, v); end
        end
    endtask

    task automatic test_gnt_delay();
        tick();
        set_ex(1'b0, 1'b1, 3'b010, 5'd3, 1'b1, 64'h2004, 64'hCAFEBABE, 1'b1);
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
        @(negedge clk);
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL gd_stall_T: got %b want 1", stall); end
        for (int c = 0; c < 4; c++) begin
            tick();
            mem_bus.gnt = (c == 3);
            @(negedge clk);
            tests_run++; if (mem_bus.req !== 1'b1) begin tests_failed++; $display("FAIL gd_req[%0d]: got %b want 1", c, mem_bus.req); end
            tests_run++; if (mem_bus.addr !== 64'h2000) begin tests_failed++; $display("FAIL gd_addr[%0d]: got %h want 2000", c, mem_bus.addr); end
            tests_run++; if (mem_bus.wdata !== 64'hCAFEBABE00000000) begin tests_failed++; $display("FAIL gd_wdata[%0d]: got %h want cafebabe00000000", c, mem_bus.wdata); end
            tests_run++; if (mem_bus.wmask !== 8'hF0) begin tests_failed++; $display("FAIL gd_wmask[%0d]: got %h want f0", c, mem_bus.wmask); end
            tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL gd_stall_req[%0d]: got %b want 1", c, stall); end
        end
        tick();
        mem_bus.gnt = 1'b0;
        @(negedge clk);
        tests_run++; if (mem_bus.req !== 1'b0) begin tests_failed++; $display("FAIL gd_req_resp: got %b want 0", mem_bus.req); end
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL gd_stall_resp: got %b want 1", stall); end
        tick();
        mem_bus.rvalid = 1'b1;
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL gd_stall_ack: got %b want 0", stall); end
        tick();
        mem_bus.rvalid = 1'b0;
        clear_ex();
        @(negedge clk);
        $display("[TB] store sw addr=2004 after 3 gnt-low cycles -> valid=%b wen=%b", inst_valid_q, w_rd_ena_q);
        tests_run++; if (inst_valid_q !== 1'b1) begin tests_failed++; $display("FAIL gd_valid: got %b want 1", inst_valid_q); end
        tests_run++; if (w_rd_ena_q !== 1'b0) begin tests_failed++; $display("FAIL gd_wen: got %b want 0", w_rd_ena_q); end
    endtask

    task automatic test_misalign();
        tick();
        set_ex(1'b1, 1'b0, 3'b010, 5'd7, 1'b1, 64'h1002, 64'd0, 1'b1);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL mis_stall: got %b want 0", stall); end
        tests_run++; if (mem_bus.req !== 1'b0) begin tests_failed++; $display("FAIL mis_req_T: got %b want 0", mem_bus.req); end
        tick();
        clear_ex();
        @(negedge clk);
        $display("[TB] lw misaligned addr=1002 -> misalign=%b valid=%b", misalign, inst_valid_q);
        tests_run++; if (misalign !== 1'b1) begin tests_failed++; $display("FAIL mis_pulse: got %b want 1", misalign); end
        tests_run++; if (inst_valid_q !== 1'b0) begin tests_failed++; $display("FAIL mis_valid: got %b want 0", inst_valid_q); end
        tests_run++; if (w_rd_ena_q !== 1'b0) begin tests_failed++; $display("FAIL mis_wen: got %b want 0", w_rd_ena_q); end
        tests_run++; if (mem_bus.req !== 1'b0) begin tests_failed++; $display("FAIL mis_req_T1: got %b want 0", mem_bus.req); end
        tick();
        @(negedge clk);
        tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse_end: got %b want 0", misalign); end
    endtask

    task automatic test_back_to_back();
        tick();
        set_ex(1'b0, 1'b0, 3'd0, 5'd3, 1'b1, 64'hDEADBEEF01234567, 64'd0, 1'b1);
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL alu_stall: got %b want 0", stall); end
        tick();
        set_ex(1'b0, 1'b0, 3'd0, 5'd4, 1'b0, 64'h55, 64'd0, 1'b1);
        @(negedge clk);
        $display("[TB] alu rd=3 -> wb_data=%h rd=%0d wen=%b", wb_data, rd_q, w_rd_ena_q);
        tests_run++; if (wb_data !== 64'hDEADBEEF01234567) begin tests_failed++; $display("FAIL alu1_data: got %h want deadbeef01234567", wb_data); end
        tests_run++; if (rd_q !== 5'd3) begin tests_failed++; $display("FAIL alu1_rd: got %0d want 3", rd_q); end
        tests_run++; if (w_rd_ena_q !== 1'b1) begin tests_failed++; $display("FAIL alu1_wen: got %b want 1", w_rd_ena_q); end
        tests_run++; if (inst_valid_q !== 1'b1) begin tests_failed++; $display("FAIL alu1_valid: got %b want 1", inst_valid_q); end
        tick();
        clear_ex();
        @(negedge clk);
        $display("[TB] alu rd=4 -> wb_data=%h rd=%0d wen=%b", wb_data, rd_q, w_rd_ena_q);
        tests_run++; if (wb_data !== 64'h55) begin tests_failed++; $display("FAIL alu2_data: got %h want 55", wb_data); end
        tests_run++; if (rd_q !== 5'd4) begin tests_failed++; $display("FAIL alu2_rd: got %0d want 4", rd_q); end
        tests_run++; if (w_rd_ena_q !== 1'b0) begin tests_failed++; $display("FAIL alu2_wen: got %b want 0", w_rd_ena_q); end
    endtask

    task automatic test_reset_mid();
        tick();
        set_ex(1'b1, 1'b0, 3'b011, 5'd8, 1'b1, 64'h1008, 64'd0, 1'b1);
        tick();
        mem_bus.gnt = 1'b1;
        tick();
        mem_bus.gnt = 1'b0;
        rst = 1'b0;
        clear_ex();
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rm_stall_in_reset: got %b want 0", stall); end
        tick();
        rst = 1'b1;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 64'hA5A5A5A5A5A5A5A5;
        @(negedge clk);
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL rm_stall_idle: got %b want 0", stall); end
        tests_run++; if (mem_bus.req !== 1'b0) begin tests_failed++; $display("FAIL rm_req: got %b want 0", mem_bus.req); end
        tests_run++; if (inst_valid_q !== 1'b0) begin tests_failed++; $display("FAIL rm_valid_reset: got %b want 0", inst_valid_q); end
        tick();
        mem_bus.rvalid = 1'b0;
        @(negedge clk);
        $display("[TB] reset during RESP, late rvalid -> valid=%b wen=%b wb_data=%h", inst_valid_q, w_rd_ena_q, wb_data);
        tests_run++; if (inst_valid_q !== 1'b0) begin tests_failed++; $display("FAIL rm_valid: got %b want 0", inst_valid_q); end
        tests_run++; if (w_rd_ena_q !== 1'b0) begin tests_failed++; $display("FAIL rm_wen: got %b want 0", w_rd_ena_q); end
        tests_run++; if (wb_data !== 64'd0) begin tests_failed++; $display("FAIL rm_wb_data: got %h want 0", wb_data); end
    endtask

    initial begin
        test_reset();
        test_load_d();
        test_load_extend();
        test_store();
        test_gnt_delay();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
